positadd_raw_pipe: RTL and testbench



---
 rtl/posit_raw_pkg.sv | 21 ++
 rtl/positadd_raw_align.sv | 103 ++++++++++
 rtl/positadd_raw_pipe.sv | 124 ++++++++++++
 tb/tb_positadd_raw_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/posit_raw_pkg.sv
// rtl/posit_raw_pkg.sv - shared widths, field offsets and ES3 product defaults for raw posit values
package posit_raw_pkg;

  localparam int ES3_SW = 10;
  localparam int ES3_FW = 54;
  localparam int DEF_GB = 3;

  // raw layout from the LSB up: zero, inf, fraction, scale, sgn
  localparam int ZERO_POS = 0;
  localparam int INF_POS  = 1;
  localparam int FRAC_LSB = 2;

  function automatic int raw_w(input int sw, input int fw);
    return sw + fw + 3;
  endfunction

  function automatic int sum_w(input int sw, input int fw, input int gb);
    return (sw + 1) + (fw + gb) + 3;
  endfunction

endpackage

// File: rtl/positadd_raw_align.sv
// rtl/positadd_raw_align.sv - S1 canonicalise/compare/swap and S2 sticky right-shift alignment
module positadd_raw_align import posit_raw_pkg::*; #(
  parameter int FW = ES3_FW,
  parameter int SW = ES3_SW,
  parameter int GB = DEF_GB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     in_valid,
  input  logic [raw_w(SW, FW)-1:0] a_raw,
  input  logic [raw_w(SW, FW)-1:0] b_raw,
  input  logic                     op_sub,
  output logic                     out_valid,
  output logic                     sgn,
  output logic [SW-1:0]            scale,
  output logic [FW+GB:0]           hi_man,
  output logic [FW+GB:0]           lo_man,
  output logic                     sticky,
  output logic                     eff_sub,
  output logic                     inf
);
  localparam int MW = FW + GB + 1;

  typedef struct packed {
    logic          sgn;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic          inf;
    logic          zero;
  } op_t;

  function automatic op_t canon(input logic [raw_w(SW, FW)-1:0] raw, input logic flip);
    op_t o;
    o.zero  = raw[ZERO_POS];
    o.inf   = raw[INF_POS] & ~o.zero;
    o.frac  = o.zero ? '0 : raw[FRAC_LSB +: FW];
    o.scale = o.zero ? '0 : raw[FRAC_LSB+FW +: SW];
    o.sgn   = ~o.zero & (raw[FRAC_LSB+FW+SW] ^ flip);
    return o;
  endfunction

  op_t  a, b, hi, lo;
  logic swap;

  always_comb begin
    a = canon(a_raw, 1'b0);
    b = canon(b_raw, op_sub);
    if (a.zero | b.zero)       swap = a.zero & ~b.zero;
    else if (a.scale != b.scale) swap = $signed(b.scale) > $signed(a.scale);
    else                       swap = b.frac > a.frac;
    hi = swap ? b : a;
    lo = swap ? a : b;
  end

  logic          v1, sgn1, hi_zero1, lo_zero1, eff1, inf1;
  logic [SW-1:0] scale1;
  logic [FW-1:0] hi_frac1, lo_frac1;
  logic [SW:0]   d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; sgn1 <= 1'b0; hi_zero1 <= 1'b0; lo_zero1 <= 1'b0; eff1 <= 1'b0; inf1 <= 1'b0;
      scale1 <= '0; hi_frac1 <= '0; lo_frac1 <= '0; d1 <= '0;
    end else if (adv) begin
      v1       <= in_valid;
      sgn1     <= hi.sgn;
      scale1   <= hi.scale;
      hi_zero1 <= hi.zero;
      hi_frac1 <= hi.frac;
      lo_zero1 <= lo.zero;
      lo_frac1 <= lo.frac;
      d1       <= {hi.scale[SW-1], hi.scale} - {lo.scale[SW-1], lo.scale};
      eff1     <= hi.sgn ^ lo.sgn;
      inf1     <= hi.inf | lo.inf;
    end
  end

  // only the upper half of the double-width shift survives; lo_m bits not re-covered by lo_sh<<d are lost
  logic [MW-1:0] lo_m, lo_sh;

  always_comb begin
    lo_m  = {~lo_zero1, lo_frac1, {GB{1'b0}}};
    lo_sh = lo_m >> d1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; sgn <= 1'b0; scale <= '0; hi_man <= '0; lo_man <= '0;
      sticky <= 1'b0; eff_sub <= 1'b0; inf <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      sgn       <= sgn1;
      scale     <= scale1;
      hi_man    <= {~hi_zero1, hi_frac1, {GB{1'b0}}};
      lo_man    <= lo_sh;
      sticky    <= |(lo_m ^ (lo_sh << d1));
      eff_sub   <= eff1;
      inf       <= inf1;
    end
  end

endmodule

// File: rtl/positadd_raw_pipe.sv
// rtl/positadd_raw_pipe.sv - six-stage raw posit adder with global-stall valid/ready handshake
module positadd_raw_pipe import posit_raw_pkg::*; #(
  parameter int FW = ES3_FW,
  parameter int SW = ES3_SW,
  parameter int GB = DEF_GB
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [raw_w(SW, FW)-1:0]     in1,
  input  logic [raw_w(SW, FW)-1:0]     in2,
  input  logic                         op_sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sum_w(SW, FW, GB)-1:0] result,
  output logic                         truncated
);
  localparam int MW  = FW + GB + 1;
  localparam int FRW = FW + GB;
  localparam int OSW = SW + 1;
  localparam int LW  = $clog2(MW + 1);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic                     v0, sub0;
  logic [raw_w(SW, FW)-1:0] a0, b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; sub0 <= 1'b0; a0 <= '0; b0 <= '0;
    end else if (adv) begin
      v0 <= in_valid; sub0 <= op_sub; a0 <= in1; b0 <= in2;
    end
  end

  logic          v2, sgn2, sticky2, eff2, inf2;
  logic [SW-1:0] scale2;
  logic [MW-1:0] hi2, lo2;

  positadd_raw_align #(.FW(FW), .SW(SW), .GB(GB)) u_align (
    .clk(clk), .rst(rst), .adv(adv), .in_valid(v0),
    .a_raw(a0), .b_raw(b0), .op_sub(sub0),
    .out_valid(v2), .sgn(sgn2), .scale(scale2), .hi_man(hi2), .lo_man(lo2),
    .sticky(sticky2), .eff_sub(eff2), .inf(inf2)
  );

  logic          v3, sgn3, sticky3, inf3;
  logic [SW-1:0] scale3;
  logic [MW:0]   sum3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0; sgn3 <= 1'b0; sticky3 <= 1'b0; inf3 <= 1'b0; scale3 <= '0; sum3 <= '0;
    end else if (adv) begin
      v3      <= v2;
      sgn3    <= sgn2;
      sticky3 <= sticky2;
      inf3    <= inf2;
      scale3  <= scale2;
      sum3    <= eff2 ? ({1'b0, hi2} - {1'b0, lo2}) : ({1'b0, hi2} + {1'b0, lo2});
    end
  end

  // leading zeros below the carry bit; an all-zero sum reports MW
  logic [LW-1:0] lz;

  always_comb begin
    lz = LW'(MW);
    for (int i = 0; i < MW; i++)
      if (sum3[i]) lz = LW'(MW - 1 - i);
  end

  logic          v4, sgn4, sticky4, inf4;
  logic [SW-1:0] scale4;
  logic [MW:0]   sum4;
  logic [LW-1:0] lz4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4 <= 1'b0; sgn4 <= 1'b0; sticky4 <= 1'b0; inf4 <= 1'b0; scale4 <= '0; sum4 <= '0; lz4 <= '0;
    end else if (adv) begin
      v4 <= v3; sgn4 <= sgn3; sticky4 <= sticky3; inf4 <= inf3;
      scale4 <= scale3; sum4 <= sum3; lz4 <= lz;
    end
  end

  logic           sgn_n, zero_n, trunc_n;
  logic [OSW-1:0] scale_x, scale_n;
  logic [FRW-1:0] frac_n;

  always_comb begin
    scale_x = {scale4[SW-1], scale4};
    zero_n  = ~inf4 & (sum4 == '0);
    sgn_n   = sgn4 & ~zero_n;
    if (sum4[MW]) begin
      frac_n  = sum4[MW-1:1];
      scale_n = scale_x + OSW'(1);
      trunc_n = sticky4 | sum4[0];
    end else begin
      frac_n  = FRW'(sum4[MW-1:0] << lz4);
      scale_n = scale_x - OSW'(lz4);
      trunc_n = sticky4;
    end
    if (zero_n) begin
      frac_n  = '0;
      scale_n = '0;
      trunc_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0; truncated <= 1'b0;
    end else if (adv) begin
      out_valid <= v4;
      result    <= {sgn_n, scale_n, frac_n, inf4, zero_n};
      truncated <= trunc_n;
    end
  end

endmodule

// File: tb/tb_positadd_raw_pipe.sv
// tb/tb_positadd_raw_pipe.sv - directed self-checking bench for positadd_raw_pipe
module tb_positadd_raw_pipe;
  localparam int FW  = 54;
  localparam int SW  = 10;
  localparam int GB  = 3;
  localparam int IW  = SW + FW + 3;
  localparam int OW  = (SW + 1) + (FW + GB) + 3;
  localparam int FRW = FW + GB;
  localparam int OSW = SW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in1 = '0;
  logic [IW-1:0] in2 = '0;
  logic          op_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] result;
  logic          truncated;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  positadd_raw_pipe #(.FW(FW), .SW(SW), .GB(GB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .truncated(truncated)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic s, input int sc, input logic [3:0] f4,
                                       input logic inf, input logic z);
    logic [SW-1:0] scv;
    scv = SW'(sc);
    return {s, scv, f4, {(FW-4){1'b0}}, inf, z};
  endfunction

  function automatic logic [FRW-1:0] fo(input logic [3:0] f4);
    return {f4, {(FRW-4){1'b0}}};
  endfunction

  function automatic logic [OW-1:0] mo(input logic s, input int sc, input logic [FRW-1:0] fr, input logic z);
    logic [OSW-1:0] scv;
    scv = OSW'(sc);
    return {s, scv, fr, 1'b0, z};
  endfunction

  task automatic run_one(input string tag, input logic sub, input logic [IW-1:0] a, input logic [IW-1:0] b,
                         input logic [OW-1:0] exp_r, input logic [OW-1:0] mask,
                         input logic exp_t, input logic chk_t, input logic chk_lat);
    int lat;
    in1 = a; in2 = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (chk_lat) check({tag, "_lat"}, lat, 6);
    check({tag, "_res"}, result & mask, exp_r & mask);
    if (chk_t) check({tag, "_trunc"}, truncated, exp_t);
    @(posedge clk); #1;
  endtask

  logic          sub_v[10];
  logic [IW-1:0] a_v[10];
  logic [IW-1:0] b_v[10];
  logic [OW-1:0] r_v[10];
  logic          t_v[10];
  logic [IW-1:0] tiny;
  int            got_n;
  logic          seen;

  initial begin
    sub_v[0] = 0; a_v[0] = mk(0, 0, 4'b0000, 0, 0); b_v[0] = mk(0, -57, 4'b0000, 0, 0); r_v[0] = mo(0, 0, FRW'(1), 0);       t_v[0] = 0;
    sub_v[1] = 0; a_v[1] = mk(0, 0, 4'b1000, 0, 0); b_v[1] = mk(0, 0, 4'b0000, 0, 0);   r_v[1] = mo(0, 1, fo(4'b0100), 0);   t_v[1] = 0;
    sub_v[2] = 1; a_v[2] = mk(0, 1, 4'b1000, 0, 0); b_v[2] = mk(0, 0, 4'b0000, 0, 0);   r_v[2] = mo(0, 1, fo(4'b0000), 0);   t_v[2] = 0;
    sub_v[3] = 1; a_v[3] = mk(0, 0, 4'b0000, 0, 0); b_v[3] = mk(0, 1, 4'b1000, 0, 0);   r_v[3] = mo(1, 1, fo(4'b0000), 0);   t_v[3] = 0;
    sub_v[4] = 0; a_v[4] = mk(1, 0, 4'b0100, 0, 0); b_v[4] = mk(1, 0, 4'b0100, 0, 0);   r_v[4] = mo(1, 1, fo(4'b0100), 0);   t_v[4] = 0;
    sub_v[5] = 0; a_v[5] = mk(0, 0, 4'b0000, 0, 0); b_v[5] = mk(0, -1, 4'b1000, 0, 0);  r_v[5] = mo(0, 0, fo(4'b1100), 0);   t_v[5] = 0;
    sub_v[6] = 1; a_v[6] = mk(0, 0, 4'b0000, 0, 0); b_v[6] = mk(0, -1, 4'b1000, 0, 0);  r_v[6] = mo(0, -2, fo(4'b0000), 0);  t_v[6] = 0;
    sub_v[7] = 0; a_v[7] = mk(1, 5, 4'b1111, 0, 1); b_v[7] = mk(1, 1, 4'b1000, 0, 0);   r_v[7] = mo(1, 1, fo(4'b1000), 0);   t_v[7] = 0;
    sub_v[8] = 0; a_v[8] = mk(0, 0, 4'b0000, 0, 0); b_v[8] = mk(0, -58, 4'b0000, 0, 0); r_v[8] = mo(0, 0, fo(4'b0000), 0);   t_v[8] = 1;
    sub_v[9] = 1; a_v[9] = mk(0, 1, 4'b0000, 0, 0); b_v[9] = mk(0, 1, 4'b0000, 0, 0);   r_v[9] = mo(0, 0, fo(4'b0000), 1);   t_v[9] = 0;

    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_trunc", truncated, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_one("one_plus_one", 0, mk(0, 0, 4'b0000, 0, 0), mk(0, 0, 4'b0000, 0, 0),
            mo(0, 1, fo(4'b0000), 0), '1, 0, 1, 1);
    run_one("one_minus_one", 1, mk(0, 0, 4'b0000, 0, 0), mk(0, 0, 4'b0000, 0, 0),
            mo(0, 0, fo(4'b0000), 1), '1, 0, 1, 1);
    run_one("onehalf_neg_half", 0, mk(0, 0, 4'b1000, 0, 0), mk(1, -1, 4'b0000, 0, 0),
            mo(0, 0, fo(4'b0000), 0), '1, 0, 1, 0);
    tiny = mk(0, -200, 4'b1111, 0, 0);
    tiny[FW+1:2] = '1;
    run_one("one_plus_tiny", 0, mk(0, 0, 4'b0000, 0, 0), tiny,
            mo(0, 0, fo(4'b0000), 0), '1, 1, 1, 0);
    run_one("inf_plus_zero", 0, mk(0, 0, 4'b0000, 1, 0), mk(0, 0, 4'b0000, 0, 1),
            OW'(2), OW'(3), 0, 0, 0);
    run_one("inf_plus_three", 0, mk(0, 0, 4'b0000, 1, 0), mk(0, 1, 4'b1000, 0, 0),
            OW'(2), OW'(3), 0, 0, 0);

    got_n = 0;
    fork
      begin : drv
        for (int i = 0; i < 10; i++) begin
          logic acc;
          int   guard;
          in1 = a_v[i]; in2 = b_v[i]; op_sub = sub_v[i]; in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
          end while (!acc && guard < 50);
        end
        in_valid = 1'b0;
      end
      begin : ctl
        for (int c = 0; c < 40; c++) begin
          out_ready = !(c >= 8 && c <= 11);
          if (c == 9) begin
            #2;
            check("stall_in_ready", in_ready, 0);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin : col
        for (int c = 0; c < 100 && got_n < 10; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            check($sformatf("stream%0d_res", got_n), result, r_v[got_n]);
            check($sformatf("stream%0d_trunc", got_n), truncated, t_v[got_n]);
            got_n++;
          end
        end
        check("stream_count", got_n, 10);
      end
    join

    for (int j = 0; j < 8; j++) begin
      in1 = a_v[j]; in2 = b_v[j]; op_sub = sub_v[j]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_trunc", truncated, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
